// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RISC-V fetch stage owning the PC and feeding decode through a prefetch FIFO.
// Redirects from EX flush the FIFO and restart fetch at the word-aligned target.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] A_instr,
    input  logic [31:0] instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_err
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          PW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fill_e;

    logic [31:0]   pc;
    logic [63:0]   fifo [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, count;
    logic [63:0]   head;
    fill_e         fill;
    logic          pop, push;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p[AW-1:0] == AW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        fill     = (count == '0) ? EMPTY : (count == PW'(DEPTH)) ? FULL : PARTIAL;
        pop      = (fill != EMPTY) && if_ready;
        push     = !redirect && (fill != FULL || pop);
        head     = fifo[rd_ptr[AW-1:0]];
        A_instr  = pc;
        if_valid = fill != EMPTY;
        if_instr = if_valid ? head[31:0] : NOP;
        if_pc    = if_valid ? head[63:32] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
        end else if (redirect) begin
            pc           <= {redirect_pc[31:2], 2'b00};
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            misalign_err <= misalign_err | (|redirect_pc[1:0]);
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + PW'(push) - PW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr[AW-1:0]] <= {pc, instr};
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the pipelined RISC-V core. It owns the program counter and drives the word address into `instruction_mem`, which is combinational: `A_instr` in, `instr` out in the same cycle. Each fetched `{pc, instr}` pair is captured into a small prefetch FIFO and presented to decode over a valid/ready handshake. It also accepts taken-branch/jump redirects from EX, which flush everything already fetched.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value after reset; must be word-aligned.
- `DEPTH`, default `2`: prefetch FIFO entries; legal values are powers of two, 2..8.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `A_instr`, out, 32: address to `instruction_mem`; always equals the current PC register.
- `instr`, in, 32: instruction word returned by `instruction_mem` for `A_instr` in the same cycle.
- `redirect`, in, 1: taken branch/jump from EX.
- `redirect_pc`, in, 32: redirect target; sampled only when `redirect`=1.
- `if_valid`, out, 1: FIFO head is valid.
- `if_ready`, in, 1: decode accepts the head this cycle.
- `if_instr`, out, 32: head instruction; `32'h0000_0013` (NOP) whenever `if_valid`=0.
- `if_pc`, out, 32: head PC; `0` whenever `if_valid`=0.
- `misalign_err`, out, 1: sticky; set when a redirect target has `redirect_pc[1:0]` != 0.

## Operation

- **State:** PC register; FIFO storage (`DEPTH` × 64 bits); read pointer, write pointer and count, each `$clog2(DEPTH)+1` bits wide; `misalign_err` flag.
- **Reset (async, `rst_n`=0):** PC=`RESET_PC`, pointers=0, count=0, `misalign_err`=0. Outputs are then `if_valid`=0, `if_instr`=NOP, `if_pc`=0, `A_instr`=`RESET_PC`. Reset asserted mid-operation discards the FIFO contents immediately.
- **Pop:** occurs when `if_valid` && `if_ready`.
- **Push:** occurs when `!redirect` and (count < `DEPTH` or pop). Writes `{A_instr, instr}` at the write pointer and sets PC ← PC+4.
  - PC arithmetic is modulo 2^32: `32'hFFFF_FFFC` + 4 = `0`.
- **Full without pop:** no push; PC holds; `A_instr` is stable.
- **Simultaneous push and pop when full:** both occur; count is unchanged.
- **Empty:** a pop cannot occur because `if_valid`=0; `if_ready` is ignored.
- **Redirect (highest priority):**
  - FIFO is flushed: pointers=0, count=0.
  - PC ← `{redirect_pc[31:2], 2'b00}`.
  - No push that cycle, and any pop that cycle is ignored. Decode must treat that cycle's handshake as void.
  - If `redirect_pc[1:0]` != 0, `misalign_err` ← 1. It stays set until reset.
- **Pointer wrap:** pointers wrap modulo `DEPTH`.
- **FSM:** the only sequencing is the FIFO's EMPTY / PARTIAL / FULL condition, derived from count. There is no other FSM.

## Timing

- **Fetch-to-decode latency:** 1 cycle. An instruction addressed in cycle N is at the head with `if_valid`=1 in cycle N+1 if the FIFO was empty.
- **After reset release:** the first rising edge pushes `RESET_PC`; `if_valid`=1 from the following cycle.
- **Redirect penalty:** with `redirect` at edge N:
  - cycle after N: `if_valid`=0 and `A_instr`=target;
  - edge N+1: target instruction pushed;
  - `if_valid`=1 with `if_pc`=target after edge N+1.
- **Sustained throughput:** with `if_ready` held at 1, one instruction per cycle and no bubbles.
- **Stall recovery:** after a stall fills the FIFO, deasserting the stall restarts the push in the same cycle as the first pop.
- **Output registering:** `if_instr`/`if_pc` are read from the registered FIFO head. There is no combinational path from `instr` to the `if_*` outputs.

## Test plan

Memory is preloaded with: [0]=`00000013`, [1]=`00100093`, [2]=`00200113`, [3]=`00308193`.

- **Reset and stream:** `rst_n` low for 2 cycles, then high with `if_ready`=1 → on consecutive cycles `if_pc`/`if_instr` = 0/`00000013`, 4/`00100093`, 8/`00200113`, 12/`00308193`; `if_valid` never drops.
- **Stall:** `if_ready`=0 for 5 cycles after reset → count saturates at 2; `A_instr` holds at 8; `if_pc` holds at 0. Releasing `if_ready` → 0, 4, 8, 12 delivered with no duplicates and no skips.
- **Redirect:** redirect to 12 while the head is at PC 4 → the next cycle has `if_valid`=0; the cycle after has `if_pc`=12, `if_instr`=`00308193`; PCs 4 and 8 are never accepted.
- **Redirect with pop collision:** `redirect` and `if_ready`=1 in the same cycle with a valid head → FIFO empty afterwards; the target appears 2 cycles later.
- **Misaligned redirect:** `redirect_pc`=`32'h0000_0006` → `misalign_err`=1 and persists; fetch resumes at 4 (`00100093`).
- **Wrap and async reset:** with `RESET_PC`=`32'hFFFF_FFF8`, stream → PCs `FFFF_FFF8`, `FFFF_FFFC`, `0`, `4`. Asserting `rst_n` low mid-stream between edges → `if_valid`=0 and `A_instr`=`RESET_PC` immediately.
